// File: rtl/mux_rr_pkg.sv
// Shared types and helpers for the round-robin mux scheduler.
package mux_rr_pkg;

  localparam int unsigned N_REQ = 8;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } state_e;

  // Single source for the mux code map: requester i is selected by S = 7 - i.
  function automatic logic [2:0] sel_of(input logic [2:0] idx);
    return 3'd7 - idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, ptr itself last.
module rr_pick
  import mux_rr_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic             any,
  output logic [2:0]       win
);

  logic found;

  // Scan ptr+1 .. ptr+8 (mod 8); the 3-bit sum wraps so offset 8 lands on ptr.
  always_comb begin
    any   = |req;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!found && req[ptr + 3'(k)]) begin
        win   = ptr + 3'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler that time-shares an external 8:1 mux between 8 requesters.
// Drives the mux select, issues one-hot grants and registers the returned mux output.
module mux_rr_sched
  import mux_rr_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             mux_y,
  output logic [2:0]       sel,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             y_valid,
  output logic             y_data,
  output logic [2:0]       y_idx
);

  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       gidx_q, gidx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             y_valid_q, y_valid_d;
  logic             y_data_q, y_data_d;
  logic [2:0]       y_idx_q, y_idx_d;

  logic             pick_any;
  logic [2:0]       pick_win;

  rr_pick u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .win (pick_win)
  );

  // Next-state and registered-output logic for the IDLE/GRANT/GAP sequencer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    sel_d     = sel_q;
    busy_d    = 1'b0;
    y_valid_d = 1'b0;
    y_data_d  = y_data_q;
    y_idx_d   = y_idx_q;

    unique case (state_q)
      StIdle, StGap: begin
        if (en && pick_any) begin
          state_d         = StGrant;
          gidx_d          = pick_win;
          gnt_d[pick_win] = 1'b1;
          sel_d           = sel_of(pick_win);
          busy_d          = 1'b1;
          cnt_d           = '0;
        end else begin
          state_d = StIdle;
        end
      end

      StGrant: begin
        // Every grant cycle yields a sample, including the one where req drops.
        y_valid_d = 1'b1;
        y_data_d  = mux_y;
        y_idx_d   = gidx_q;
        if (!req[gidx_q] || (cnt_q == CntMax)) begin
          state_d = StGap;
          ptr_d   = gidx_q;
        end else begin
          cnt_d  = cnt_q + CntW'(1);
          gnt_d  = gnt_q;
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; synchronous reset overrides any tenure in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= 3'd7;
      gidx_q    <= 3'd0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      sel_q     <= 3'b000;
      busy_q    <= 1'b0;
      y_valid_q <= 1'b0;
      y_data_q  <= 1'b0;
      y_idx_q   <= 3'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_idx_q   <= y_idx_d;
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_idx   = y_idx_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Bench for mux_rr_sched: closes the loop through an 8:1 mux model, checks against a
// tenure-level reference model via scoreboard queues, plus directed scenario checks.
module tb_mux_rr_sched;

  localparam int unsigned HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] a_data = 8'h00;
  logic       mux_y;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       y_valid;
  logic       y_data;
  logic [2:0] y_idx;

  always #5 clk = ~clk;

  // 8:1 mux: S=0 selects A[7].
  assign mux_y = a_data[3'd7 - sel];

  mux_rr_sched #(
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .mux_y   (mux_y),
    .sel     (sel),
    .gnt     (gnt),
    .busy    (busy),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_idx   (y_idx)
  );

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       yv;
    logic       yd;
    logic [2:0] yi;
  } obs_t;

  obs_t       exp_q[$];
  logic [3:0] samp_q[$];
  int checks = 0;
  int errors = 0;
  int samples = 0;

  // Reference model: who owns the mux, how long, and the last-served index.
  int         m_owner = -1;
  int         m_used = 0;
  int         m_ptr = 7;
  logic [2:0] m_sel = 3'd0;
  logic       m_yv = 1'b0;
  logic       m_yd = 1'b0;
  logic [2:0] m_yi = 3'd0;

  always @(posedge clk) begin : model
    obs_t e;
    if (rst) begin
      m_owner = -1; m_used = 0; m_ptr = 7; m_sel = 3'd0;
      m_yv = 1'b0; m_yd = 1'b0; m_yi = 3'd0;
    end else if (m_owner >= 0) begin
      m_yv = 1'b1;
      m_yd = a_data[m_owner];
      m_yi = 3'(m_owner);
      samp_q.push_back({m_yi, m_yd});
      m_used++;
      if (!req[m_owner] || m_used == HOLD) begin
        m_ptr   = m_owner;
        m_owner = -1;
      end
    end else begin
      m_yv = 1'b0;
      if (en) begin
        for (int k = 1; k <= 8; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
            m_owner = (m_ptr + k) % 8;
            m_used  = 0;
            m_sel   = 3'(7 - m_owner);
          end
        end
      end
    end
    e.gnt  = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    e.sel  = m_sel;
    e.busy = (m_owner >= 0);
    e.yv   = m_yv;
    e.yd   = m_yv ? m_yd : 1'b0;
    e.yi   = m_yv ? m_yi : 3'd0;
    exp_q.push_back(e);
  end

  // Monitor: compares DUT outputs on the falling edge.
  always @(negedge clk) begin : monitor
    obs_t e;
    obs_t act;
    logic [3:0] s;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {gnt, sel, busy, y_valid, y_valid ? y_data : 1'b0, y_valid ? y_idx : 3'd0};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle_state t=%0t: got gnt=%h sel=%0d busy=%b yv=%b yd=%b yi=%0d expected gnt=%h sel=%0d busy=%b yv=%b yd=%b yi=%0d",
                 $time, act.gnt, act.sel, act.busy, act.yv, act.yd, act.yi,
                 e.gnt, e.sel, e.busy, e.yv, e.yd, e.yi);
      end
    end
    if (y_valid) begin
      samples++;
      checks++;
      if (samp_q.size() == 0) begin
        errors++;
        $display("FAIL sample t=%0t: got y_idx=%0d y_data=%b expected no sample", $time, y_idx, y_data);
      end else begin
        s = samp_q.pop_front();
        if ({y_idx, y_data} !== s) begin
          errors++;
          $display("FAIL sample t=%0t: got y_idx=%0d y_data=%b expected y_idx=%0d y_data=%b",
                   $time, y_idx, y_data, s[3:1], s[0]);
        end
      end
    end
    checks++;
    if (!$onehot0(gnt) || (busy != (gnt != 8'h00))) begin
      errors++;
      $display("FAIL invariant t=%0t: got gnt=%h busy=%b expected onehot0 gnt matching busy",
               $time, gnt, busy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (busy) got = 1'b1;
    end
    check(name, 32'(got), 32'd1);
  endtask

  function automatic int idx_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin : stim
    int got_order[$];
    logic [7:0] prev;
    int s0;
    int n;

    // Reset values and a single held requester.
    a_data = 8'h3c;
    do_reset();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_yv", 32'(y_valid), 32'h0);
    check("rst_yd", 32'(y_data), 32'h0);
    check("rst_yi", 32'(y_idx), 32'h0);
    req = 8'h08;
    en  = 1'b1;
    wait_busy("single_busy");
    check("single_gnt", 32'(gnt), 32'h08);
    check("single_sel", 32'(sel), 32'h4);
    repeat (15) step();

    // All requesting: strict rotation starting at index 0.
    do_reset();
    req  = 8'hff;
    prev = 8'h00;
    for (int i = 0; i < 80 && got_order.size() < 9; i++) begin
      step();
      if (busy && gnt != prev) got_order.push_back(idx_of(gnt));
      prev = gnt;
    end
    check("rot_count", 32'(got_order.size()), 32'd9);
    foreach (got_order[k]) check($sformatf("rot_order[%0d]", k), 32'(got_order[k]), 32'(k % 8));

    // Data path through the mux.
    do_reset();
    a_data = 8'b1010_0101;
    req    = 8'h20;
    wait_busy("data_busy");
    for (int i = 0; i < 8; i++) begin
      step();
      if (y_valid) check("data_y", 32'(y_data), 32'h1);
      if (busy) check("data_sel", 32'(sel), 32'h2);
    end

    // Early release after two grant cycles, then pointer check.
    do_reset();
    s0  = samples;
    req = 8'h04;
    wait_busy("drop_busy");
    step();
    req = 8'h00;
    repeat (3) step();
    check("drop_samples", 32'(samples - s0), 32'd2);
    req = 8'h06;
    wait_busy("drop_next_busy");
    check("drop_next_gnt", 32'(gnt), 32'h02);
    repeat (6) step();

    // Reset in the third grant cycle.
    do_reset();
    req = 8'hff;
    wait_busy("midrst_busy");
    step();
    step();
    check("midrst_pre_gnt", 32'(gnt), 32'h01);
    req = 8'h08;
    wait_busy("midrst_b2");
    step();
    step();
    rst = 1'b1;
    step();
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_sel", 32'(sel), 32'h0);
    check("midrst_yv", 32'(y_valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    req = 8'hff;
    wait_busy("midrst_after");
    check("midrst_winner", 32'(gnt), 32'h01);
    repeat (4) step();

    // Enable gating: no grant while disabled, tenure completes once started.
    do_reset();
    en  = 1'b0;
    req = 8'h81;
    n   = 0;
    repeat (10) begin
      step();
      if (busy) n++;
    end
    check("en0_busy_cycles", 32'(n), 32'd0);
    en = 1'b1;
    n  = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (busy) begin
        n++;
        en = 1'b0;
      end
    end
    check("en_drop_tenure", 32'(n), 32'(HOLD));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      req    = 8'($urandom) & 8'($urandom);
      en     = ($urandom_range(0, 9) != 0);
      a_data = 8'($urandom);
      rst    = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    req = 8'h00;
    repeat (8) step();
    check("samp_q_drained", 32'(samp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
